// File: rtl/decryptor_pkg.sv
// Shared AES types, key-length encoding and GF(2^8) helpers used by the
// inverse cipher and its leaf cells.
package decryptor_pkg;

  typedef logic [127:0] aes_128;

  typedef enum logic [1:0] {
    NOOP    = 2'd0,
    ENC_128 = 2'd1,
    ENC_192 = 2'd2,
    ENC_256 = 2'd3
  } mode;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [3:0] nr_of(input mode m);
    logic [3:0] n;
    case (m)
      ENC_128: n = NR_128;
      ENC_192: n = NR_192;
      ENC_256: n = NR_256;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of repeated xtime terms.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      acc = acc ^ (k[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  function automatic aes_128 inv_shift_rows(input aes_128 s);
    aes_128 r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 32*c - 8*w -: 8] = s[127 - 32*((c + 4 - w) % 4) - 8*w -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decryptor_if.sv
// Request/response bundle between the key store / ciphertext source and the
// inverse cipher; master is the supplier side, slave is the decryptor.
interface decryptor_if;
  import decryptor_pkg::*;

  aes_128     data_i;
  aes_128     kw_i;
  mode        mode_i;
  logic       valid_i;
  aes_128     data_o;
  logic       data_valid_o;
  logic       ready_o;
  logic [3:0] round_o;

  modport master (
    output data_i, kw_i, mode_i, valid_i,
    input  data_o, data_valid_o, ready_o, round_o
  );

  modport slave (
    input  data_i, kw_i, mode_i, valid_i,
    output data_o, data_valid_o, ready_o, round_o
  );

endinterface

// File: rtl/bInvSbox.sv
// Inverse S-box leaf: one byte through the shared lookup table.
module bInvSbox
  import decryptor_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = inv_sbox(a_i);

endmodule

// File: rtl/decryptor_inv_mix_col.sv
// InvMixColumns on a single 32-bit column (row0 in the top byte).
module decryptor_inv_mix_col
  import decryptor_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0_s, a1_s, a2_s, a3_s;

  assign {a0_s, a1_s, a2_s, a3_s} = col_i;

  assign col_o = {
    gf_mul(a0_s, 4'he) ^ gf_mul(a1_s, 4'hb) ^ gf_mul(a2_s, 4'hd) ^ gf_mul(a3_s, 4'h9),
    gf_mul(a0_s, 4'h9) ^ gf_mul(a1_s, 4'he) ^ gf_mul(a2_s, 4'hb) ^ gf_mul(a3_s, 4'hd),
    gf_mul(a0_s, 4'hd) ^ gf_mul(a1_s, 4'h9) ^ gf_mul(a2_s, 4'he) ^ gf_mul(a3_s, 4'hb),
    gf_mul(a0_s, 4'hb) ^ gf_mul(a1_s, 4'hd) ^ gf_mul(a2_s, 4'h9) ^ gf_mul(a3_s, 4'he)
  };

endmodule

// File: rtl/decryptor.sv
// AES inverse cipher (128/192/256-bit keys), one round per clock. Round keys
// come from an external key store: round_o names the index, kw_i returns it.
module decryptor
  import decryptor_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  decryptor_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0] fsm_q, fsm_d;
  aes_128     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  mode        mode_q, mode_d;
  aes_128     data_q, data_d;
  logic       data_valid_q, data_valid_d;
  logic       ready_s;
  logic [3:0] round_s;
  aes_128     shifted_s, sub_s, ark_s, mixed_s;

  // ROUND and FINAL share the same InvShiftRows/InvSubBytes/AddRoundKey path.
  assign shifted_s = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    bInvSbox u_sbox (.a_i(shifted_s[8*i +: 8]), .y_o(sub_s[8*i +: 8]));
  end

  assign ark_s = sub_s ^ bus.kw_i;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    decryptor_inv_mix_col u_mix (.col_i(ark_s[32*c +: 32]), .col_o(mixed_s[32*c +: 32]));
  end

  // Next-state, key index and handshake decode
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    rnd_d        = rnd_q;
    mode_d       = mode_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    ready_s      = 1'b0;
    round_s      = 4'd0;
    case (fsm_q)
      S_IDLE: begin
        ready_s = 1'b1;
        round_s = nr_of(bus.mode_i);
        if (bus.valid_i && (bus.mode_i != NOOP)) begin
          state_d = bus.data_i ^ bus.kw_i;
          mode_d  = bus.mode_i;
          rnd_d   = nr_of(bus.mode_i) - 4'd1;
          fsm_d   = S_ROUND;
        end else begin
          fsm_d   = S_IDLE;
        end
      end
      S_ROUND: begin
        round_s = rnd_q;
        state_d = mixed_s;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          fsm_d = S_FINAL;
        end else begin
          fsm_d = S_ROUND;
        end
      end
      S_FINAL: begin
        round_s      = 4'd0;
        data_d       = ark_s;
        data_valid_d = 1'b1;
        fsm_d        = S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // State, round counter and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      state_q      <= 128'h0;
      rnd_q        <= 4'd0;
      mode_q       <= NOOP;
      data_q       <= 128'h0;
      data_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      mode_q       <= mode_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.ready_o      = ready_s;
  assign bus.round_o      = round_s;
  assign bus.data_o       = data_q;
  assign bus.data_valid_o = data_valid_q;

endmodule

// File: tb/tb_decryptor.sv
// Scoreboard bench: plaintexts are encrypted by a forward-AES model in the
// bench, the DUT must recover them; a monitor checks every result and handshake.
module tb_decryptor;
  import decryptor_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  decryptor_if bus ();
  decryptor dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam aes_128 FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam aes_128 CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam aes_128 CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam aes_128 CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] sbox [256];
  aes_128 rk_next [16];
  aes_128 rk_cur [16];
  aes_128 exp_q [$];
  int due_q [$];
  bit have_blk = 1'b0;
  int blk_start = 0;
  int blk_nr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Key store: the pending request's schedule while idle, the active block's otherwise.
  assign bus.kw_i = bus.ready_o ? rk_next[bus.round_o] : rk_cur[bus.round_o];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic int nk_of(input mode m);
    case (m)
      ENC_128: return 4;
      ENC_192: return 6;
      ENC_256: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int bnr(input mode m);
    return (m == NOOP) ? 0 : nk_of(m) + 6;
  endfunction

  // Forward S-box from first principles: GF(2^8) inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0] rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_next[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic aes_128 sub_bytes(input aes_128 s);
    aes_128 r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox[s[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic aes_128 shift_rows(input aes_128 s);
    aes_128 r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 32*c - 8*w -: 8] = s[127 - 32*((c + w) % 4) - 8*w -: 8];
    return r;
  endfunction

  function automatic aes_128 mix_columns(input aes_128 s);
    aes_128 r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      r[127 - 32*c -: 32] = {gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                             a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                             a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                             gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)};
    end
    return r;
  endfunction

  function automatic aes_128 encrypt(input aes_128 pt, input int nr);
    aes_128 s;
    s = pt ^ rk_next[0];
    for (int r = 1; r <= nr; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r != nr) s = mix_columns(s);
      s = s ^ rk_next[r];
    end
    return s;
  endfunction

  // Present a request (keys already in rk_next); returns the accept cycle.
  task automatic send(input aes_128 ct, input mode m, input aes_128 pt, output int acc);
    int n;
    bus.data_i = ct;
    bus.mode_i = m;
    bus.valid_i = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ready_o never rose (cycle %0d)", cyc);
      acc = -1;
      return;
    end
    acc = cyc;
    exp_q.push_back(pt);
    due_q.push_back(cyc + bnr(m) + 1);
    blk_start = cyc;
    blk_nr = bnr(m);
    have_blk = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rk_cur[i] = rk_next[i];
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_i("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: scoreboard pops on each result, handshake checked every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.data_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid: data_o=%h with no block outstanding (cycle %0d)", bus.data_o, cyc);
        end else begin
          chk("data_o", bus.data_o, exp_q.pop_front());
          chk_i("latency", cyc, due_q.pop_front());
        end
      end
      if (have_blk && cyc > blk_start && cyc <= blk_start + blk_nr) begin
        chk_i("ready_busy", int'(bus.ready_o), 0);
        chk_i("round_busy", int'(bus.round_o), blk_start + blk_nr - cyc);
      end else begin
        chk_i("ready_idle", int'(bus.ready_o), 1);
        chk_i("round_idle", int'(bus.round_o), bnr(bus.mode_i));
      end
    end
  end

  initial begin
    int a1, a2;
    aes_128 pt, ct;
    logic [255:0] key;
    mode m;
    rst_n = 1'b0;
    bus.data_i = 128'h0;
    bus.mode_i = NOOP;
    bus.valid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rk_next[i] = 128'h0;
      rk_cur[i] = 128'h0;
    end
    build_sbox();
    repeat (3) @(negedge clk);
    chk("rst_data_o", bus.data_o, 128'h0);
    chk_i("rst_valid", int'(bus.data_valid_o), 0);
    chk_i("rst_ready", int'(bus.ready_o), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 known answers for each key length
    expand(FIPS_KEY, 4);
    send(CT_128, ENC_128, FIPS_PT, a1);
    bus.valid_i = 1'b0;
    wait_idle();
    expand(FIPS_KEY, 6);
    send(CT_192, ENC_192, FIPS_PT, a1);
    bus.valid_i = 1'b0;
    wait_idle();
    expand(FIPS_KEY, 8);
    send(CT_256, ENC_256, FIPS_PT, a1);
    bus.valid_i = 1'b0;
    wait_idle();

    // NOOP requests are ignored
    bus.mode_i = NOOP;
    bus.valid_i = 1'b1;
    bus.data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (5) @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);

    // Back-to-back with valid_i held high
    expand(FIPS_KEY, 4);
    send(CT_128, ENC_128, FIPS_PT, a1);
    expand(FIPS_KEY, 8);
    send(CT_256, ENC_256, FIPS_PT, a2);
    chk_i("b2b_accept", a2, a1 + 11);
    bus.valid_i = 1'b0;
    wait_idle();

    // Input churn while busy
    expand(FIPS_KEY, 8);
    send(CT_256, ENC_256, FIPS_PT, a1);
    for (int i = 0; i < 10; i++) begin
      bus.valid_i = 1'($urandom_range(0, 1));
      bus.mode_i = mode'($urandom_range(0, 3));
      bus.data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.mode_i = NOOP;
    wait_idle();

    // Random keys, plaintexts, modes and gaps
    for (int it = 0; it < 8; it++) begin
      m = mode'($urandom_range(1, 3));
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(key, nk_of(m));
      ct = encrypt(pt, bnr(m));
      send(ct, m, pt, a1);
      if ($urandom_range(0, 1) == 1) begin
        bus.valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    bus.valid_i = 1'b0;
    wait_idle();

    // Reset at round 5 of a block, then a fresh block
    expand(FIPS_KEY, 4);
    send(CT_128, ENC_128, FIPS_PT, a1);
    bus.valid_i = 1'b0;
    while (cyc < a1 + 5) @(negedge clk);
    rst_n = 1'b0;
    have_blk = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    chk("abort_data_o", bus.data_o, 128'h0);
    chk_i("abort_valid", int'(bus.data_valid_o), 0);
    chk_i("abort_ready", int'(bus.ready_o), 1);
    chk_i("abort_round", int'(bus.round_o), 10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(CT_128, ENC_128, FIPS_PT, a1);
    bus.valid_i = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
